// File: rtl/gmii_pkg.sv
// Shared GMII constants, receive FSM states and the end-of-frame status record.
// Also used by the transmit path for FCS generation.
package gmii_pkg;

  localparam logic [7:0]  GMII_PREAMBLE = 8'h55;
  localparam logic [7:0]  GMII_SFD      = 8'hD5;
  localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;
  localparam logic [3:0]  PRE_LIMIT     = 4'd15;
  localparam logic [10:0] LEN_SAT       = 11'h7FF;

  typedef enum logic [1:0] {
    IDLE,
    PREAMBLE,
    DATA,
    DROP
  } gmii_rx_state_e;

  typedef struct packed {
    logic [10:0] len;
    logic        crc_err;
    logic        len_err;
    logic        phy_err;
    logic        pre_err;
  } gmii_rx_stat_t;

  // Bytes go on the wire LSB first, so the CRC engine works on the bit-reversed polynomial.
  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// Combinational one-byte step of the reflected CRC-32 (no final inversion).
// The caller owns the register; the same block serves RX checking and TX FCS generation.
module crc32_d8
  import gmii_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  localparam logic [31:0] POLY_REFL = reflect32(CRC32_POLY);

  always_comb begin
    logic [31:0] c;
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) begin
        c = (c >> 1) ^ POLY_REFL;
      end else begin
        c = c >> 1;
      end
    end
    crc_out = c;
  end

endmodule

// File: rtl/gmii_rx_mac.sv
// GMII receive MAC: strips preamble/SFD, checks CRC and length, optionally removes the FCS
// and emits framed bytes plus a one-cycle status pulse per frame.
module gmii_rx_mac
  import gmii_pkg::*;
#(
  parameter int MIN_FRAME = 64,
  parameter int MAX_FRAME = 1518,
  parameter bit STRIP_FCS = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_en,
  input  logic [7:0]  rxd,
  input  logic        rx_er,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_sop,
  output logic        out_eop,
  output logic        out_err,
  output logic        stat_valid,
  output logic [10:0] stat_len,
  output logic        stat_crc_err,
  output logic        stat_len_err,
  output logic        stat_phy_err,
  output logic        stat_pre_err
);

  // Four FCS bytes of holdback plus the pending byte; the pending byte alone when FCS is forwarded.
  localparam int          DEPTH   = STRIP_FCS ? 5 : 1;
  localparam logic [2:0]  DEPTH_L = 3'(DEPTH);
  localparam logic [10:0] MIN_L   = 11'(MIN_FRAME);
  localparam logic [10:0] MAX_L   = 11'(MAX_FRAME);

  gmii_rx_state_e state_reg, state_next;
  logic [3:0]     pre_cnt_reg;
  logic [31:0]    crc_reg, crc_next;
  logic [10:0]    len_reg;
  logic           phy_err_reg;
  logic           sop_pend_reg;
  logic [2:0]     held_reg;
  logic [7:0]     hold_reg [DEPTH];
  gmii_rx_stat_t  stat_reg, stat_end;

  logic take_byte, frame_end, drop_end, sfd_seen, pre_inc;
  logic pipe_full, frame_bad;

  crc32_d8 u_crc (
    .crc_in  (crc_reg),
    .data    (rxd),
    .crc_out (crc_next)
  );

  always_comb begin
    state_next = state_reg;
    take_byte  = 1'b0;
    frame_end  = 1'b0;
    drop_end   = 1'b0;
    sfd_seen   = 1'b0;
    pre_inc    = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (rx_en) begin
          if (rxd == GMII_PREAMBLE) begin
            state_next = PREAMBLE;
          end else if (rxd == GMII_SFD) begin
            state_next = DATA;
            sfd_seen   = 1'b1;
          end else begin
            state_next = DROP;
          end
        end
      end
      PREAMBLE: begin
        if (!rx_en) begin
          state_next = IDLE;
        end else if (rxd == GMII_SFD) begin
          state_next = DATA;
          sfd_seen   = 1'b1;
        end else if (rxd == GMII_PREAMBLE && pre_cnt_reg != PRE_LIMIT) begin
          pre_inc = 1'b1;
        end else begin
          state_next = DROP;
        end
      end
      DATA: begin
        if (rx_en) begin
          take_byte = 1'b1;
        end else begin
          frame_end  = 1'b1;
          state_next = IDLE;
        end
      end
      DROP: begin
        if (!rx_en) begin
          drop_end   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign pipe_full = (held_reg == DEPTH_L);

  always_comb begin
    stat_end.len     = len_reg;
    stat_end.crc_err = (crc_reg != CRC32_RESIDUE);
    stat_end.len_err = (len_reg < MIN_L) || (len_reg > MAX_L);
    stat_end.phy_err = phy_err_reg;
    stat_end.pre_err = 1'b0;
    frame_bad = stat_end.crc_err | stat_end.len_err | stat_end.phy_err;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      pre_cnt_reg  <= 4'd1;
      crc_reg      <= CRC32_INIT;
      len_reg      <= '0;
      phy_err_reg  <= 1'b0;
      sop_pend_reg <= 1'b0;
      held_reg     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        hold_reg[i] <= '0;
      end
      out_data     <= '0;
      out_valid    <= 1'b0;
      out_sop      <= 1'b0;
      out_eop      <= 1'b0;
      out_err      <= 1'b0;
      stat_valid   <= 1'b0;
      stat_reg     <= '0;
    end else begin
      state_reg  <= state_next;
      out_valid  <= 1'b0;
      out_sop    <= 1'b0;
      out_eop    <= 1'b0;
      out_err    <= 1'b0;
      stat_valid <= 1'b0;

      // The entry 0x55 counts as the first preamble byte.
      if (state_reg != PREAMBLE) begin
        pre_cnt_reg <= 4'd1;
      end else if (pre_inc) begin
        pre_cnt_reg <= pre_cnt_reg + 4'd1;
      end

      if (sfd_seen) begin
        crc_reg      <= CRC32_INIT;
        len_reg      <= '0;
        phy_err_reg  <= 1'b0;
        held_reg     <= '0;
        sop_pend_reg <= 1'b1;
      end

      if (take_byte) begin
        crc_reg <= crc_next;
        if (len_reg != LEN_SAT) begin
          len_reg <= len_reg + 11'd1;
        end
        if (rx_er) begin
          phy_err_reg <= 1'b1;
        end
        hold_reg[0] <= rxd;
        for (int i = 1; i < DEPTH; i++) begin
          hold_reg[i] <= hold_reg[i-1];
        end
        if (pipe_full) begin
          out_valid    <= 1'b1;
          out_data     <= hold_reg[DEPTH-1];
          out_sop      <= sop_pend_reg;
          sop_pend_reg <= 1'b0;
        end else begin
          held_reg <= held_reg + 3'd1;
        end
      end

      // Everything is reinitialised here so a preamble on the very next cycle is accepted.
      if (frame_end) begin
        if (pipe_full) begin
          out_valid <= 1'b1;
          out_data  <= hold_reg[DEPTH-1];
          out_sop   <= sop_pend_reg;
          out_eop   <= 1'b1;
          out_err   <= frame_bad;
        end
        stat_valid   <= 1'b1;
        stat_reg     <= stat_end;
        crc_reg      <= CRC32_INIT;
        len_reg      <= '0;
        phy_err_reg  <= 1'b0;
        held_reg     <= '0;
        sop_pend_reg <= 1'b0;
      end

      if (drop_end) begin
        stat_valid <= 1'b1;
        stat_reg   <= '{len: '0, crc_err: 1'b0, len_err: 1'b0, phy_err: 1'b0, pre_err: 1'b1};
      end
    end
  end

  assign stat_len     = stat_reg.len;
  assign stat_crc_err = stat_reg.crc_err;
  assign stat_len_err = stat_reg.len_err;
  assign stat_phy_err = stat_reg.phy_err;
  assign stat_pre_err = stat_reg.pre_err;

endmodule

// File: doc/gmii_rx_mac.md
Name: gmii_rx_mac

Overview:
- MAC-side GMII receiver: consumes the PHY→MAC receive signals (rx_en, rxd, rx_er), strips preamble/SFD, optionally strips FCS, checks CRC-32 and length, and emits a byte stream with frame delimiters plus a per-frame status pulse.
- Counterpart of the MAC transmit path driving tx_en/txd/tr_er. Sits between the GMII pins and the MAC RX FIFO.
- No backpressure: GMII cannot stall.

Parameters:
- MIN_FRAME, 64, minimum legal length in bytes after SFD, FCS included.
- MAX_FRAME, 1518, maximum legal length in bytes, FCS included.
- STRIP_FCS, 1, 1 = remove the 4 FCS bytes from out_data; 0 = forward them.

Ports:
- clk  in  1  GMII receive clock, 125 MHz.
- reset  in  1  asynchronous, active-low reset.
- rx_en  in  1  receive data valid from PHY.
- rxd  in  8  receive data from PHY.
- rx_er  in  1  receive error from PHY.
- out_data  out  8  frame byte.
- out_valid  out  1  out_data valid this cycle.
- out_sop  out  1  first byte of frame; qualified by out_valid.
- out_eop  out  1  last byte of frame; qualified by out_valid.
- out_err  out  1  frame bad (CRC, length or PHY error); valid with out_eop only.
- stat_valid  out  1  one-cycle end-of-frame status pulse.
- stat_len  out  11  bytes after SFD including FCS, saturating at 2047.
- stat_crc_err  out  1  CRC residue mismatch; qualified by stat_valid.
- stat_len_err  out  1  length < MIN_FRAME or > MAX_FRAME; qualified by stat_valid.
- stat_phy_err  out  1  rx_er seen during DATA; qualified by stat_valid.
- stat_pre_err  out  1  bad preamble/SFD, frame dropped; qualified by stat_valid.

Behaviour:
- Reset (reset=0, async): all outputs 0, FSM=IDLE, CRC=32'hFFFFFFFF, counters and pipeline cleared.
- FSM states: IDLE, PREAMBLE, DATA, DROP.
- IDLE:
  - rx_en=1 & rxd=8'h55 → PREAMBLE.
  - rx_en=1 & rxd=8'hD5 → DATA (short preamble accepted).
  - rx_en=1 & other → DROP.
- PREAMBLE:
  - 8'h55 → stay; preamble counter +1.
  - 8'hD5 → DATA.
  - Other byte, or more than 15 × 8'h55 → DROP.
  - rx_en=0 → IDLE silently, no stat.
- DROP: wait for rx_en=0, then issue stat_valid with stat_pre_err=1 and stat_len=0, → IDLE. No out_valid for dropped frames.
- DATA, each rx_en=1 cycle:
  - CRC updated with rxd; length +1 (saturating); rx_er=1 sets sticky phy_err.
  - FCS holdback: STRIP_FCS=1 uses a 4-byte holdback plus 1 pending byte; STRIP_FCS=0 uses the pending byte only.
  - Incoming byte arrives while pending is valid → pending byte emitted with out_eop=0; out_sop=1 on the first emitted byte of the frame.
- Latency (STRIP_FCS=1): frame byte k (k=0 first after SFD) is registered onto out_data at the edge sampling byte k+5. With STRIP_FCS=0: at the edge sampling byte k+1.
- End of frame (DATA, rx_en=0):
  - Pending byte emitted with out_eop=1 and out_err = crc_err|len_err|phy_err.
  - stat_valid pulses on the same edge.
  - FSM → IDLE; CRC, count and pipeline reinitialised on that edge, so a new preamble in the very next cycle is accepted.
- Error rules:
  - CRC: reflected CRC-32, poly 32'h04C11DB7, init 32'hFFFFFFFF, over all bytes after SFD including FCS. Good frame ⇔ raw register == 32'hDEBB20E3 at end.
  - len_err: stat_len < MIN_FRAME or > MAX_FRAME. Oversize frames are still received to the end and forwarded.
- Runt below 5 bytes (STRIP_FCS=1): no byte emitted, no out_eop; stat_valid still pulses with len_err=1 (and crc_err as computed).
- rx_er with rx_en=0 (carrier extension/false carrier) is ignored in every state.
- Reset mid-frame: immediate clear. After release with rx_en=1 mid-frame, the FSM enters DROP unless rxd is 8'h55 or 8'hD5.
- out_valid is never asserted in IDLE, PREAMBLE or DROP.

Decomposition:
- Package gmii_pkg holds:
  - constants GMII_PREAMBLE=8'h55, GMII_SFD=8'hD5, CRC32_POLY, CRC32_INIT, CRC32_RESIDUE=32'hDEBB20E3;
  - typedef enum gmii_rx_state_e {IDLE, PREAMBLE, DATA, DROP};
  - typedef struct gmii_rx_stat_t.
- One sub-module, crc32_d8: combinational 8-bit-parallel next-CRC, shared later with the TX path for FCS generation.

Test Plan:
- Min frame: 7×55, D5, 60 payload bytes 00..3B, correct FCS → out_valid ×60, sop on 00, eop on 3B, out_err=0, stat_len=64, all stat errs 0.
- Same frame with one payload bit flipped → eop with out_err=1, stat_crc_err=1, stat_len=64.
- Bad preamble: 55 55 A5 … → no out_valid; at rx_en fall stat_pre_err=1, stat_len=0.
- rx_er=1 for one cycle mid-payload in a 100-byte frame → stat_phy_err=1, out_err=1 on eop; byte count unchanged.
- Back-to-back: frame A, rx_en low 1 cycle, then frame B (64 bytes each) → two complete sop/eop sequences and two stat_valid pulses, both clean. Same with STRIP_FCS=0 → 64 bytes out per frame.
- Reset asserted at payload byte 30 of a 1518-byte frame → outputs 0 immediately. After release mid-frame → DROP, stat_pre_err=1 at rx_en fall. Next good 1519-byte frame → stat_len_err=1, all 1515 bytes forwarded.
